// File: rtl/imm_encoder_if.sv
// Request/response bundle for the RISC-V immediate encoder.
// Request: in_valid/in_ready, in_fmt, in_imm, in_rd/rs1/rs2, in_funct3, in_opcode.
// Response: out_valid/out_ready, out_instr, out_err, out_last.
interface imm_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_fmt;
   logic [31:0] in_imm;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_opcode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_err;
   logic        out_last;

   modport master (
      output in_valid, in_fmt, in_imm, in_rd, in_rs1, in_rs2,
      output in_funct3, in_opcode, out_ready,
      input  in_ready, out_valid, out_instr, out_err, out_last
   );

   modport slave (
      input  in_valid, in_fmt, in_imm, in_rd, in_rs1, in_rs2,
      input  in_funct3, in_opcode, out_ready,
      output in_ready, out_valid, out_instr, out_err, out_last
   );
endinterface

// File: rtl/imm_encoder.sv
// Encodes I/S/B/J/U instruction words and the LI pseudo-op from fields.
// Ports: clk, rst_n (async low), bus (slave side), instr_count, err_count.
module imm_encoder (
   input  logic        clk,
   input  logic        rst_n,
   imm_encoder_if.slave bus,
   output logic [15:0] instr_count,
   output logic [7:0]  err_count
);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      LI_HI
   } state_t;

   localparam logic [6:0] OP_IMM = 7'h13;
   localparam logic [6:0] OP_LUI = 7'h37;

   state_t      state;
   logic [31:0] pend_instr;

   logic [31:0] imm;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  f3;
   logic [6:0]  op;

   logic        f_i;
   logic        f_s;
   logic        f_b;
   logic        f_j;
   logic        f_u;
   logic        f_li;

   logic        ok12;
   logic        ok13;
   logic        ok21;
   logic [19:0] li_hi;

   logic [31:0] w_i;
   logic [31:0] w_s;
   logic [31:0] w_b;
   logic [31:0] w_j;
   logic [31:0] w_u;
   logic [31:0] w_li_lo;
   logic [31:0] w_li_hi;
   logic [31:0] w_li_add;

   logic [31:0] enc_instr;
   logic        enc_err;
   logic        enc_last;

   logic        accept;
   logic        fire;

   assign imm = bus.in_imm;
   assign rd  = bus.in_rd;
   assign rs1 = bus.in_rs1;
   assign rs2 = bus.in_rs2;
   assign f3  = bus.in_funct3;
   assign op  = bus.in_opcode;

   assign f_i  = (bus.in_fmt == 3'b000);
   assign f_s  = (bus.in_fmt == 3'b001);
   assign f_b  = (bus.in_fmt == 3'b010);
   assign f_j  = (bus.in_fmt == 3'b011);
   assign f_u  = (bus.in_fmt == 3'b100);
   assign f_li = (bus.in_fmt == 3'b101);

   // Sign-extension checks: upper bits must all be copies of the sign.
   assign ok12 = (&imm[31:11]) | ~(|imm[31:11]);
   assign ok13 = (&imm[31:12]) | ~(|imm[31:12]);
   assign ok21 = (&imm[31:20]) | ~(|imm[31:20]);

   // (imm + 0x800)[31:12]: the low half only carries when imm[11] is set,
   // which pre-compensates the sign-extended ADDI that follows the LUI.
   assign li_hi = imm[31:12] + {19'd0, imm[11]};

   assign w_i = {imm[11:0], rs1, f3, rd, op};
   assign w_s = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
   assign w_b = {imm[12], imm[10:5], rs2, rs1, f3,
                 imm[4:1], imm[11], op};
   assign w_j = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
   assign w_u = {imm[31:12], rd, op};

   assign w_li_lo  = {imm[11:0], 5'd0, 3'd0, rd, OP_IMM};
   assign w_li_hi  = {li_hi, rd, OP_LUI};
   assign w_li_add = {imm[11:0], rd, 3'd0, rd, OP_IMM};

   // Reserved formats fall to the default: a NOP flagged as an error.
   always_comb begin
      enc_instr = {25'd0, OP_IMM};
      enc_err   = 1'b1;
      enc_last  = 1'b1;
      unique case (1'b1)
         f_i: begin
            enc_instr = w_i;
            enc_err   = ~ok12;
         end
         f_s: begin
            enc_instr = w_s;
            enc_err   = ~ok12;
         end
         f_b: begin
            enc_instr = w_b;
            enc_err   = ~ok13 | imm[0];
         end
         f_j: begin
            enc_instr = w_j;
            enc_err   = ~ok21 | imm[0];
         end
         f_u: begin
            enc_instr = w_u;
            enc_err   = |imm[11:0];
         end
         f_li: begin
            enc_err = 1'b0;
            if (ok12) begin
               enc_instr = w_li_lo;
            end else begin
               enc_instr = w_li_hi;
               enc_last  = 1'b0;
            end
         end
         default: begin
         end
      endcase
   end

   // HOLD can take a new request in the cycle its word drains.
   assign bus.in_ready = (state == IDLE) |
                         ((state == HOLD) & bus.out_ready);

   assign accept = bus.in_valid & bus.in_ready;
   assign fire   = bus.out_valid & bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         bus.out_valid <= 1'b0;
         bus.out_instr <= 32'd0;
         bus.out_err   <= 1'b0;
         bus.out_last  <= 1'b0;
         pend_instr    <= 32'd0;
         instr_count   <= 16'd0;
         err_count     <= 8'd0;
      end else begin
         if (fire) begin
            instr_count <= instr_count + 16'd1;
         end
         if (accept && enc_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
         if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_instr <= enc_instr;
            bus.out_err   <= enc_err;
            bus.out_last  <= enc_last;
            pend_instr    <= w_li_add;
            state         <= enc_last ? HOLD : LI_HI;
         end else begin
            unique case (state)
               HOLD: begin
                  if (fire) begin
                     bus.out_valid <= 1'b0;
                     state         <= IDLE;
                  end
               end
               LI_HI: begin
                  if (fire) begin
                     bus.out_instr <= pend_instr;
                     bus.out_err   <= 1'b0;
                     bus.out_last  <= 1'b1;
                     state         <= HOLD;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: formats, LI, flow control, counters.
// Drives on the falling edge, samples on the falling edge after each rise.
module tb_imm_encoder;

   logic        clk;
   logic        rst_n;
   logic [15:0] instr_count;
   logic [7:0]  err_count;

   int tests;
   int fails;
   int exp_cnt;
   int exp_err;

   imm_encoder_if bus ();

   imm_encoder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .instr_count (instr_count),
      .err_count   (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic put(input logic [2:0] fmt, input logic [31:0] imm,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] op);
      bus.in_valid  = 1'b1;
      bus.in_fmt    = fmt;
      bus.in_imm    = imm;
      bus.in_rd     = rd;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_funct3 = f3;
      bus.in_opcode = op;
   endtask

   task automatic test_reset;
      rst_n         = 1'b0;
      bus.out_ready = 1'b0;
      put(3'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
      bus.in_valid  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
      exp_err = 0;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'd0 ||
          bus.out_err !== 1'b0 || bus.out_last !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: got v=%b i=%h e=%b l=%b want 0",
                  bus.out_valid, bus.out_instr, bus.out_err,
                  bus.out_last);
      end
      tests++;
      if (instr_count !== 16'd0 || err_count !== 8'd0) begin
         fails++;
         $display("FAIL reset_counters: got %0d/%0d want 0/0",
                  instr_count, err_count);
      end
      tests++;
      if (bus.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_branch;
      bus.out_ready = 1'b1;
      put(3'd2, 32'hFFFF_FFFC, 5'd0, 5'd1, 5'd2, 3'd1, 7'h63);
      step;
      bus.in_valid = 1'b0;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hFE20_9EE3 ||
          bus.out_err !== 1'b0 || bus.out_last !== 1'b1) begin
         fails++;
         $display("FAIL b_ok: got v=%b i=%h e=%b l=%b want 1 fe209ee3 0 1",
                  bus.out_valid, bus.out_instr, bus.out_err,
                  bus.out_last);
      end
      step;
      exp_cnt++;
      put(3'd2, 32'd3, 5'd0, 5'd1, 5'd2, 3'd1, 7'h63);
      step;
      bus.in_valid = 1'b0;
      exp_err++;
      tests++;
      if (bus.out_instr !== 32'h0020_9163 || bus.out_err !== 1'b1) begin
         fails++;
         $display("FAIL b_err: got i=%h e=%b want 00209163 1",
                  bus.out_instr, bus.out_err);
      end
      tests++;
      if (err_count !== 8'd1) begin
         fails++;
         $display("FAIL b_err_count: got %0d want 1", err_count);
      end
      step;
      exp_cnt++;
      tests++;
      if (bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL b_drain: got out_valid %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_formats;
      logic [2:0]  fm [9];
      logic [31:0] im [9];
      logic [31:0] ew [9];
      logic        ee [9];
      fm = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd3, 3'd4, 3'd4, 3'd6, 3'd7};
      im = '{32'hFFFF_FFFF, 32'h0000_0800, 32'hFFFF_FFF8,
             32'h0000_0800, 32'h0010_0000, 32'hABCD_E000,
             32'h0000_1001, 32'h1234_5678, 32'h0};
      ew = '{32'hFFF1_0093, 32'h8001_0093, 32'hFE51_2C23,
             32'h0010_00EF, 32'h8000_00EF, 32'hABCD_E3B7,
             32'h0000_13B7, 32'h0000_0013, 32'h0000_0013};
      ee = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      bus.out_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         case (fm[k])
            3'd0: put(fm[k], im[k], 5'd1, 5'd2, 5'd0, 3'd0, 7'h13);
            3'd1: put(fm[k], im[k], 5'd0, 5'd2, 5'd5, 3'd2, 7'h23);
            3'd3: put(fm[k], im[k], 5'd1, 5'd0, 5'd0, 3'd0, 7'h6F);
            3'd4: put(fm[k], im[k], 5'd7, 5'd0, 5'd0, 3'd0, 7'h37);
            default: put(fm[k], im[k], 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F);
         endcase
         step;
         bus.in_valid = 1'b0;
         if (ee[k]) exp_err++;
         tests++;
         if (bus.out_valid !== 1'b1 || bus.out_instr !== ew[k] ||
             bus.out_err !== ee[k] || bus.out_last !== 1'b1) begin
            fails++;
            $display("FAIL fmt_%0d: got v=%b i=%h e=%b l=%b want 1 %h %b 1",
                     k, bus.out_valid, bus.out_instr, bus.out_err,
                     bus.out_last, ew[k], ee[k]);
         end
         step;
         exp_cnt++;
      end
      tests++;
      if (instr_count !== 16'(exp_cnt) || err_count !== 8'(exp_err)) begin
         fails++;
         $display("FAIL fmt_counters: got %0d/%0d want %0d/%0d",
                  instr_count, err_count, exp_cnt, exp_err);
      end
   endtask

   task automatic test_li_pair;
      bus.out_ready = 1'b1;
      put(3'd5, 32'h1234_5FFF, 5'd5, 5'd7, 5'd8, 3'd6, 7'h7F);
      step;
      bus.in_valid = 1'b0;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h1234_62B7 ||
          bus.out_last !== 1'b0 || bus.out_err !== 1'b0) begin
         fails++;
         $display("FAIL li_lui: got v=%b i=%h l=%b e=%b want 1 123462b7 0 0",
                  bus.out_valid, bus.out_instr, bus.out_last, bus.out_err);
      end
      tests++;
      if (bus.in_ready !== 1'b0) begin
         fails++;
         $display("FAIL li_in_ready: got %b want 0", bus.in_ready);
      end
      step;
      exp_cnt++;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hFFF2_8293 ||
          bus.out_last !== 1'b1 || bus.out_err !== 1'b0) begin
         fails++;
         $display("FAIL li_addi: got v=%b i=%h l=%b e=%b want 1 fff28293 1 0",
                  bus.out_valid, bus.out_instr, bus.out_last, bus.out_err);
      end
      step;
      exp_cnt++;
      tests++;
      if (bus.out_valid !== 1'b0 || err_count !== 8'(exp_err)) begin
         fails++;
         $display("FAIL li_done: got v=%b errc=%0d want 0 %0d",
                  bus.out_valid, err_count, exp_err);
      end
   endtask

   task automatic test_stall;
      bus.out_ready = 1'b0;
      put(3'd5, 32'd100, 5'd3, 5'd4, 5'd6, 3'd5, 7'h01);
      step;
      put(3'd0, 32'd7, 5'd9, 5'd9, 5'd0, 3'd0, 7'h13);
      for (int c = 0; c < 5; c++) begin
         tests++;
         if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h0640_0193 ||
             bus.out_last !== 1'b1 || bus.out_err !== 1'b0 ||
             bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_%0d: got v=%b i=%h l=%b e=%b r=%b want 1 06400193 1 0 0",
                     c, bus.out_valid, bus.out_instr, bus.out_last,
                     bus.out_err, bus.in_ready);
         end
         step;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step;
      exp_cnt++;
      tests++;
      if (bus.out_valid !== 1'b0 || instr_count !== 16'(exp_cnt)) begin
         fails++;
         $display("FAIL stall_release: got v=%b cnt=%0d want 0 %0d",
                  bus.out_valid, instr_count, exp_cnt);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] ew [4];
      ew = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213};
      bus.out_ready = 1'b1;
      put(3'd0, 32'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h13);
      step;
      for (int k = 0; k < 4; k++) begin
         if (k < 3) begin
            put(3'd0, 32'(k + 2), 5'(k + 2), 5'd0, 5'd0, 3'd0, 7'h13);
         end else begin
            bus.in_valid = 1'b0;
         end
         tests++;
         if (bus.out_valid !== 1'b1 || bus.out_instr !== ew[k] ||
             bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_%0d: got v=%b i=%h r=%b want 1 %h 1",
                     k, bus.out_valid, bus.out_instr, bus.in_ready, ew[k]);
         end
         step;
         exp_cnt++;
      end
      tests++;
      if (bus.out_valid !== 1'b0 || instr_count !== 16'(exp_cnt)) begin
         fails++;
         $display("FAIL b2b_count: got v=%b cnt=%0d want 0 %0d",
                  bus.out_valid, instr_count, exp_cnt);
      end
   endtask

   task automatic test_err_saturate;
      bus.out_ready = 1'b1;
      put(3'd6, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
      repeat (256) begin
         step;
         exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      end
      bus.in_valid = 1'b0;
      step;
      exp_cnt += 256;
      tests++;
      if (err_count !== 8'(exp_err) || exp_err != 255) begin
         fails++;
         $display("FAIL err_saturate: got %0d want 255", err_count);
      end
      tests++;
      if (instr_count !== 16'(exp_cnt)) begin
         fails++;
         $display("FAIL err_sat_instr_count: got %0d want %0d",
                  instr_count, exp_cnt);
      end
   endtask

   task automatic test_reset_li_hi;
      bus.out_ready = 1'b0;
      put(3'd5, 32'h1234_5FFF, 5'd5, 5'd0, 5'd0, 3'd0, 7'h13);
      step;
      bus.in_valid = 1'b0;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b0) begin
         fails++;
         $display("FAIL rst_li_pre: got v=%b l=%b want 1 0",
                  bus.out_valid, bus.out_last);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'd0 ||
          instr_count !== 16'd0 || err_count !== 8'd0) begin
         fails++;
         $display("FAIL rst_li_async: got v=%b i=%h cnt=%0d errc=%0d want 0",
                  bus.out_valid, bus.out_instr, instr_count, err_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step;
         tests++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
             instr_count !== 16'd0) begin
            fails++;
            $display("FAIL rst_li_after_%0d: got v=%b r=%b cnt=%0d want 0 1 0",
                     c, bus.out_valid, bus.in_ready, instr_count);
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      exp_cnt = 0;
      exp_err = 0;
      @(negedge clk);
      test_reset;
      test_branch;
      test_formats;
      test_li_pair;
      test_stall;
      test_back_to_back;
      test_err_saturate;
      test_reset_li_hi;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, rising edge.
REQ-002 SHALL have ports: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: in_valid  input  1  request valid; in_ready  output  1  request accepted when both high.
REQ-004 SHALL have ports: in_fmt  input  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 LI pseudo, 110/111 reserved.
REQ-005 SHALL have ports: in_imm  input  32  signed immediate; in_rd, in_rs1, in_rs2  input  5 each; in_funct3  input  3; in_opcode  input  7.
REQ-006 SHALL have ports: out_valid  output  1; out_ready  input  1; out_instr  output  32  encoded word; out_err  output  1  range error; out_last  output  1  final word of request.
REQ-007 SHALL have ports: instr_count  output  16  output beats delivered; err_count  output  8  errored requests.

Function
REQ-008 Field placement SHALL be: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20].
REQ-009 I: imm[11:0] to [31:20], plus rd, rs1, funct3, opcode; S: imm[11:5] to [31:25], imm[4:0] to [11:7], plus rs2, rs1, funct3, opcode.
REQ-010 B: imm[12] to 31, imm[10:5] to [30:25], imm[4:1] to [11:8], imm[11] to 7, plus rs2, rs1, funct3, opcode.
REQ-011 J: imm[20] to 31, imm[10:1] to [30:21], imm[11] to 20, imm[19:12] to [19:12], plus rd, opcode; U: imm[31:12] to [31:12], plus rd, opcode.
REQ-012 Range error SHALL be flagged when: I/S imm[31:11] not uniform; B imm[31:12] not uniform or imm[0]=1; J imm[31:20] not uniform or imm[0]=1; U imm[11:0]!=0.
REQ-013 On range error, the truncated word SHALL still be emitted with out_err=1.
REQ-014 Reserved fmt SHALL emit 0x00000013 with out_err=1 and out_last=1.
REQ-015 LI SHALL ignore in_opcode, in_funct3 and in_rs*, and SHALL never set out_err.
  - If imm[31:11] is uniform: single word ADDI rd,x0,imm[11:0], out_last=1.
  - Otherwise: word 1 LUI rd,hi (opcode 0x37), out_last=0; then word 2 ADDI rd,rd,imm[11:0] (opcode 0x13, funct3 0), out_last=1.
  - hi = (imm + 0x800)[31:12], computed modulo 2^32.
REQ-016 FSM states SHALL be IDLE (no output held), HOLD (final word held), LI_HI (LUI held, ADDI pending).
REQ-017 Accepting a request SHALL produce out_valid on the next cycle: latency 1.
REQ-018 in_ready SHALL be 1 in IDLE, equal out_ready in HOLD, and 0 in LI_HI.
  - Accept plus output handshake in the same cycle in HOLD SHALL load the new word, giving one word per cycle.
REQ-019 LI_HI transitions on handshake: to HOLD with the ADDI word loaded.
REQ-020 HOLD transitions on handshake: with no new accept, to IDLE and out_valid=0.
REQ-021 While out_valid=1 and out_ready=0, out_instr, out_err and out_last SHALL be stable.
REQ-022 instr_count SHALL increment on each out_valid&out_ready and wrap at 0xFFFF to 0.
REQ-023 err_count SHALL increment on each accepted errored request and saturate at 255.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, out_valid=0, out_instr=0, out_err=0, out_last=0, instr_count=0, err_count=0.
REQ-025 After reset, in_ready SHALL be 1.
REQ-026 Reset in LI_HI SHALL discard the pending ADDI; no word is emitted after release.

Verification
REQ-027 fmt I, imm 0xFFFFFFFF, rd 1, rs1 2, funct3 0, opcode 0x13 -> out_instr 0xFFF10093, out_err 0, out_last 1, one cycle after accept.
REQ-028 fmt B, imm 0xFFFFFFFC, rs1 1, rs2 2, funct3 1, opcode 0x63 -> 0xFE209EE3.
  - Same request with imm 3 -> out_err 1, err_count 1.
REQ-029 LI, imm 0x12345FFF, rd 5 -> 0x123462B7 (out_last 0), then 0xFFF28293 (out_last 1); in_ready 0 while the first word is held.
REQ-030 LI, imm 100, rd 3 -> single 0x06400193, out_last 1; back-to-back I requests with out_ready=1 -> one word per cycle, instr_count matches.
REQ-031 Hold out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready 0.
  - 256 errored requests -> err_count 255.
REQ-032 Assert rst_n low during LI_HI -> out_valid 0 immediately, counters 0, no ADDI emitted after release.
